// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: forwarding muxes, single-cycle ALU and a
// 32-iteration shift-add multiplier that holds the upstream stages via stall.
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [121:0] IDEXReg,
  input  logic [70:0]  MEMWBReg,
  output logic [74:0]  EXMEMReg,
  output logic         stall
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1010;
  localparam logic [4:0] LAST_COUNT = 5'(MUL_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  // ID/EX fields
  logic [31:0] rd1, rd2, imm;
  logic [4:0]  rs, rt, rd;
  logic [3:0]  alu_ctl;
  logic        alu_src, reg_dst, valid;
  logic [3:0]  ctl_bits; // {RegWrite, MemWrite, MemToReg, MemRead}

  assign rd1      = IDEXReg[31:0];
  assign rd2      = IDEXReg[63:32];
  assign imm      = IDEXReg[95:64];
  assign rs       = IDEXReg[100:96];
  assign rt       = IDEXReg[105:101];
  assign rd       = IDEXReg[110:106];
  assign alu_ctl  = IDEXReg[114:111];
  assign alu_src  = IDEXReg[115];
  assign reg_dst  = IDEXReg[116];
  assign ctl_bits = {IDEXReg[120], IDEXReg[119], IDEXReg[118], IDEXReg[117]};
  assign valid    = IDEXReg[121];

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [74:0] exmem_q, exmem_d;

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, memwb_val;
  logic [4:0]  write_reg;

  // EX/MEM has priority over MEM/WB; r0 is never forwarded.
  function automatic logic [31:0] forward(input logic [4:0]  src,
                                          input logic [31:0] reg_val,
                                          input logic [74:0] exmem,
                                          input logic [70:0] memwb,
                                          input logic [31:0] wb_val);
    if (exmem[74] && exmem[68:64] != 5'd0 && exmem[68:64] == src)
      return exmem[31:0];
    else if (memwb[37] && memwb[36:32] != 5'd0 && memwb[36:32] == src)
      return wb_val;
    else
      return reg_val;
  endfunction

  assign memwb_val = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];
  assign fwd_a     = forward(rs, rd1, exmem_q, MEMWBReg, memwb_val);
  assign fwd_b     = forward(rt, rd2, exmem_q, MEMWBReg, memwb_val);
  assign op_a      = fwd_a;
  assign op_b      = alu_src ? imm : fwd_b;
  assign write_reg = reg_dst ? rd : rt;

  always_comb begin
    unique case (alu_ctl)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_NOR: alu_res = ~(op_a | op_b);
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    wdata_d  = wdata_q;
    wreg_d   = wreg_q;
    ctl_d    = ctl_q;
    exmem_d  = '0;
    stall    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid && alu_ctl == ALU_MUL) begin
          stall    = 1'b1;
          mcand_d  = op_a;
          mplier_d = op_b;
          wdata_d  = fwd_b;
          wreg_d   = write_reg;
          ctl_d    = ctl_bits;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_BUSY;
        end else if (valid) begin
          exmem_d = {ctl_bits, 2'b00, write_reg, fwd_b, alu_res};
        end
      end
      S_BUSY: begin
        acc_d   = acc_q + (mplier_q[count_q] ? (mcand_q << count_q) : 32'd0);
        count_d = count_q + 5'd1;
        if (count_q == LAST_COUNT) begin
          // Drop stall on the final iteration so ID/EX advances on the writing edge.
          exmem_d = {ctl_q, 2'b00, wreg_q, wdata_q, acc_d};
          count_d = '0;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      wdata_q  <= '0;
      wreg_q   <= '0;
      ctl_q    <= '0;
      exmem_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
      ctl_q    <= ctl_d;
      exmem_q  <= exmem_d;
    end
  end

  assign EXMEMReg = exmem_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: table of single-cycle vectors with forwarding,
// plus hand-written MUL, reset-abort and bubble sequences.
module tb_execute_stage;

  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] ADD_ = 4'b0010;
  localparam logic [3:0] SUB_ = 4'b0110;
  localparam logic [3:0] SLT_ = 4'b0111;
  localparam logic [3:0] NOR_ = 4'b1100;
  localparam logic [3:0] MUL_ = 4'b1010;
  localparam logic [3:0] BAD_ = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [121:0] idex;
  logic [70:0]  memwb;
  logic [74:0]  exmem;
  logic         stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic [121:0] idex;
    logic [70:0]  memwb;
    logic [74:0]  exp;
  } vec_t;

  vec_t vecs[10];

  execute_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IDEXReg  (idex),
    .MEMWBReg (memwb),
    .EXMEMReg (exmem),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [121:0] mk_idex(
      input logic valid, input logic rw, input logic mw, input logic m2r, input logic mr,
      input logic regdst, input logic alusrc, input logic [3:0] ctl,
      input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] rs,
      input logic [31:0] imm, input logic [31:0] rd2, input logic [31:0] rd1);
    return {valid, rw, mw, m2r, mr, regdst, alusrc, ctl, rd, rt, rs, imm, rd2, rd1};
  endfunction

  function automatic logic [70:0] mk_memwb(input logic m2r, input logic [31:0] alures,
      input logic rw, input logic [4:0] wr, input logic [31:0] rdata);
    return {m2r, alures, rw, wr, rdata};
  endfunction

  function automatic logic [74:0] mk_exmem(input logic rw, input logic mw, input logic m2r,
      input logic mr, input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] res);
    return {rw, mw, m2r, mr, 2'b00, wr, wd, res};
  endfunction

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a MUL (Rs=25, Rt=26) and follows it to the product edge.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] prod);
    idex  = mk_idex(1, 1, 0, 0, 0, 1, 0, MUL_, rd, 26, 25, 0, b, a);
    memwb = '0;
    #1;
    check({name, "_issue_stall"}, {74'd0, stall}, 75'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      // Operands were latched at issue; garbage in ID/EX must not matter.
      if (k == 1) idex = mk_idex(1, 1, 0, 0, 0, 1, 0, MUL_, rd, 26, 25, 0, 32'hDEAD, 32'hBEEF);
      #1;
      check($sformatf("%s_bubble%0d", name, k), exmem, 75'd0);
      check($sformatf("%s_stall%0d", name, k), {74'd0, stall}, {74'd0, k < 32});
    end
    tick();
    check({name, "_product"}, exmem, mk_exmem(1, 0, 0, 0, rd, b, prod));
  endtask

  initial begin
    vecs[0] = '{"add",     mk_idex(1,1,0,0,0,1,0,ADD_, 3, 2, 1,0,7,5), '0,
                mk_exmem(1,0,0,0, 3,7,12)};
    vecs[1] = '{"sub_fwd", mk_idex(1,1,0,0,0,1,0,SUB_, 5, 4, 3,0,2,0), mk_memwb(0,99,1,3,0),
                mk_exmem(1,0,0,0, 5,2,10)};
    vecs[2] = '{"sw_wbfwd",mk_idex(1,0,1,0,0,0,1,ADD_, 0, 7, 6,4,1,100),
                mk_memwb(1,32'h55,1,7,32'h40), mk_exmem(0,1,0,0, 7,32'h40,104)};
    vecs[3] = '{"slt",     mk_idex(1,1,0,0,0,1,0,SLT_,10, 9, 8,0,1,32'hFFFFFFFF), '0,
                mk_exmem(1,0,0,0,10,1,1)};
    vecs[4] = '{"nor_r0",  mk_idex(1,1,0,0,0,1,0,NOR_,11, 0, 0,0,0,0), mk_memwb(0,5,1,0,5),
                mk_exmem(1,0,0,0,11,0,32'hFFFFFFFF)};
    vecs[5] = '{"and",     mk_idex(1,1,0,0,0,1,0,AND_,14,13,12,0,32'hFF00,32'hF0F0), '0,
                mk_exmem(1,0,0,0,14,32'hFF00,32'hF000)};
    vecs[6] = '{"or_fwd",  mk_idex(1,1,0,0,0,1,0,OR_, 17,16,14,0,32'h0F,0), '0,
                mk_exmem(1,0,0,0,17,32'h0F,32'hF00F)};
    vecs[7] = '{"bad_op",  mk_idex(1,1,0,1,1,0,0,BAD_, 0,18,19,0,4,3), '0,
                mk_exmem(1,0,1,1,18,4,0)};
    vecs[8] = '{"invalid", mk_idex(0,1,0,0,0,1,0,ADD_,20, 2, 1,0,7,5), '0, 75'd0};
    vecs[9] = '{"wb_rs",   mk_idex(1,1,0,0,0,1,0,ADD_,22,21,20,0,2,1), mk_memwb(0,1000,1,20,7),
                mk_exmem(1,0,0,0,22,2,1002)};

    // Reset held for two edges with a valid ADD presented.
    rst_n = 1'b0;
    idex  = vecs[0].idex;
    memwb = '0;
    tick();
    tick();
    check("reset_exmem", exmem, 75'd0);
    check("reset_stall", {74'd0, stall}, 75'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      idex  = vecs[i].idex;
      memwb = vecs[i].memwb;
      #1;
      check({vecs[i].name, "_stall"}, {74'd0, stall}, 75'd0);
      tick();
      check(vecs[i].name, exmem, vecs[i].exp);
    end

    run_mul("mul7x6", 32'd7, 32'd6, 5'd9, 32'd42);
    // Next instruction reads r9 and must see the product via EX/MEM.
    idex = mk_idex(1,1,0,0,0,1,0,ADD_,12,0,9,0,0,0);
    #1;
    check("after_mul_stall", {74'd0, stall}, 75'd0);
    tick();
    check("after_mul_fwd", exmem, mk_exmem(1,0,0,0,12,0,42));

    run_mul("mulwrap", 32'hFFFFFFFF, 32'd2, 5'd10, 32'hFFFFFFFE);

    // Abort a MUL at count 10 with a reset; a non-MUL ADD sits in ID/EX meanwhile.
    idex = mk_idex(1,1,0,0,0,1,0,MUL_,13,26,25,0,9,9);
    for (int k = 0; k < 11; k++) tick();
    rst_n = 1'b0;
    idex  = mk_idex(1,1,0,0,0,1,0,ADD_,29,28,27,0,1,1);
    tick();
    check("abort_exmem", exmem, 75'd0);
    check("abort_stall", {74'd0, stall}, 75'd0);
    rst_n = 1'b1;
    tick();
    check("abort_then_add", exmem, mk_exmem(1,0,0,0,29,1,2));

    run_mul("mul5x3", 32'd5, 32'd3, 5'd15, 32'd15);

    idex = mk_idex(0,1,1,1,1,1,1,ADD_,7,7,7,32'h1234,32'h5678,32'h9ABC);
    #1;
    check("bubble_stall", {74'd0, stall}, 75'd0);
    tick();
    check("bubble_exmem", exmem, 75'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
